// File: rtl/fetch_sequencer.sv
// Fetch controller: sequences the external PC register through an imem request/ready
// handshake, issues captured instructions to decode and selects the next PC.
module fetch_sequencer #(
  parameter int unsigned MAX_WAIT   = 15,
  parameter bit          AUTO_START = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] retired
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_WAIT);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StIssue, StHalted, StFault} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic [31:0]   retired_q, retired_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retired_q  <= '0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retired_q  <= retired_d;
      cause_q    <= cause_d;
    end
  end

  // Redirect priority: jump over taken branch over sequential.
  always_comb begin
    if (jump) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = branch_target;
    end else begin
      target = pc_plus4;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    retired_d   = retired_q;
    cause_d     = cause_q;
    pc_en       = 1'b0;
    pc_next     = pc_plus4;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (start || AUTO_START) begin
          state_d = StReq;
        end
      end
      StReq, StWait: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        // Ready wins over a timeout landing in the same cycle.
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc;
          state_d    = StIssue;
        end else if (state_q == StReq) begin
          wait_cnt_d = CW'(1);
          state_d    = StWait;
        end else if (wait_cnt_q == MaxCnt) begin
          cause_d = 2'b01;
          state_d = StFault;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_next = target;
          if (target[1:0] != 2'b00) begin
            cause_d = 2'b10;
            state_d = StFault;
          end else if (halt) begin
            // The halting instruction retires but the PC is left on it.
            retired_d = retired_q + 32'd1;
            state_d   = StHalted;
          end else begin
            pc_en     = 1'b1;
            retired_d = retired_q + 32'd1;
            state_d   = StReq;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign retired     = retired_q;
  assign fault_cause = cause_q;
  assign busy        = (state_q == StReq) || (state_q == StWait) || (state_q == StIssue);
  assign halted      = (state_q == StHalted);
  assign fault       = (state_q == StFault);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: scoreboard of expected issued instructions and PC loads,
// plus directed status checks; a second instance covers AUTO_START and async reset.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, imem_ready = 1'b0, stall = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0, halt = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc, pc_plus4, pc_next, imem_addr, imem_rdata, instr, instr_pc, retired;
  logic        pc_en, imem_req, instr_valid, busy, halted, fault;
  logic [1:0]  fault_cause;

  logic        rst_a = 1'b1, ready_a = 1'b0;
  logic [31:0] a_pc, a_pc_plus4, a_pc_next, a_addr, a_rdata, a_instr, a_instr_pc, a_retired;
  logic        a_pc_en, a_req, a_valid, a_busy, a_halted, a_fault;
  logic [1:0]  a_cause;

  fetch_sequencer #(.MAX_WAIT(15), .AUTO_START(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .pc_plus4(pc_plus4),
    .pc_en(pc_en), .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target), .halt(halt),
    .busy(busy), .halted(halted), .fault(fault), .fault_cause(fault_cause),
    .retired(retired)
  );

  fetch_sequencer #(.MAX_WAIT(15), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .start(1'b0), .pc(a_pc), .pc_plus4(a_pc_plus4),
    .pc_en(a_pc_en), .pc_next(a_pc_next), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ready(ready_a), .imem_rdata(a_rdata), .instr_valid(a_valid),
    .instr(a_instr), .instr_pc(a_instr_pc), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .jump(1'b0), .jump_target(32'h0), .halt(1'b0),
    .busy(a_busy), .halted(a_halted), .fault(a_fault), .fault_cause(a_cause),
    .retired(a_retired)
  );

  // PC register and adder models, plus a memory returning addr ^ 0xDEAD0000.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (pc_en) pc <= pc_next;
  end
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) a_pc <= '0;
    else if (a_pc_en) a_pc <= a_pc_next;
  end
  assign pc_plus4   = pc + 32'd4;
  assign a_pc_plus4 = a_pc + 32'd4;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;
  assign a_rdata    = a_addr ^ 32'hDEAD_0000;

  int checks = 0;
  int errors = 0;
  int n_pc_en = 0;
  logic [63:0] exp_instr_q[$];
  logic [31:0] exp_next_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
    branch_target = '0; jump_target = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops an expected {instr_pc, instr} on each new issue and an expected
  // pc_next on every PC load.
  logic        valid_prev = 1'b0;
  logic [63:0] mon_e;
  logic [31:0] mon_n;
  always @(negedge clk) begin
    if (instr_valid && !valid_prev) begin
      if (exp_instr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_issue: got unexpected instr_pc %h required none", instr_pc);
      end else begin
        mon_e = exp_instr_q.pop_front();
        chk("sb_instr_pc", instr_pc, mon_e[63:32]);
        chk("sb_instr", instr, mon_e[31:0]);
      end
    end
    if (pc_en) begin
      n_pc_en++;
      if (exp_next_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_pc_en: got unexpected pc_next %h required none", pc_next);
      end else begin
        mon_n = exp_next_q.pop_front();
        chk("sb_pc_next", pc_next, mon_n);
      end
    end
    valid_prev <= instr_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  int cnt0;

  initial begin
    // 1: sequential fetch with zero-wait memory
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_retired", retired, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_instr", instr, 0);
    start = 1'b1; imem_ready = 1'b1;
    exp_instr_q.push_back({32'h0000_0000, 32'hDEAD_0000});
    exp_instr_q.push_back({32'h0000_0004, 32'hDEAD_0004});
    exp_instr_q.push_back({32'h0000_0008, 32'hDEAD_0008});
    exp_next_q.push_back(32'h4);
    exp_next_q.push_back(32'h8);
    exp_next_q.push_back(32'hC);
    step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_pc_en_req", pc_en, 0);
      step();
      chk("t1_pc_en_issue", pc_en, 1);
      step();
    end
    chk("t1_retired", retired, 3);
    chk("t1_addr_next", imem_addr, 32'hC);

    // 2: three wait cycles then ready, then a timeout
    imem_ready = 1'b0;
    exp_instr_q.push_back({32'h0000_000C, 32'hDEAD_000C});
    exp_next_q.push_back(32'h10);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_ready = 1'b1;
      chk("t2_req_held", imem_req, 1);
      chk("t2_addr_held", imem_addr, 32'hC);
      chk("t2_valid_low", instr_valid, 0);
      step();
    end
    chk("t2_valid_after_ready", instr_valid, 1);
    imem_ready = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("t2_req_wait", imem_req, 1);
      chk("t2_addr_wait", imem_addr, 32'h10);
      step();
    end
    chk("t2_fault", fault, 1);
    chk("t2_cause", fault_cause, 1);
    chk("t2_req_fault", imem_req, 0);
    chk("t2_busy_fault", busy, 0);
    chk("t2_retired", retired, 4);

    // 3: jump beats branch
    do_reset();
    chk("t3_rst_retired", retired, 0);
    chk("t3_rst_cause", fault_cause, 0);
    start = 1'b1; imem_ready = 1'b1;
    jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
    exp_instr_q.push_back({32'h0000_0000, 32'hDEAD_0000});
    exp_next_q.push_back(32'h40);
    step(); start = 1'b0;
    chk("t3_addr0", imem_addr, 0);
    chk("t3_next_req", pc_next, 32'h4);
    chk("t3_pc_en_req", pc_en, 0);
    step();
    chk("t3_pc_next", pc_next, 32'h40);
    chk("t3_pc_en", pc_en, 1);
    step();
    chk("t3_addr_jump", imem_addr, 32'h40);

    // 4: stall holds the issued instruction with a branch pending
    jump = 1'b0; branch_target = 32'h100; stall = 1'b1;
    exp_instr_q.push_back({32'h0000_0040, 32'hDEAD_0040});
    exp_next_q.push_back(32'h100);
    step();
    cnt0 = n_pc_en;
    for (int i = 0; i < 3; i++) begin
      chk("t4_valid", instr_valid, 1);
      chk("t4_instr", instr, 32'hDEAD_0040);
      chk("t4_instr_pc", instr_pc, 32'h40);
      chk("t4_pc_en", pc_en, 0);
      chk("t4_retired", retired, 1);
      step();
    end
    stall = 1'b0;
    #1;
    chk("t4_release_pc_en", pc_en, 1);
    chk("t4_release_next", pc_next, 32'h100);
    step();
    chk("t4_addr_branch", imem_addr, 32'h100);
    chk("t4_retired_after", retired, 2);
    chk("t4_single_pulse", n_pc_en - cnt0, 1);

    // 5a: misaligned branch target
    branch_target = 32'h42;
    exp_instr_q.push_back({32'h0000_0100, 32'hDEAD_0100});
    cnt0 = n_pc_en;
    step();
    chk("t5_valid", instr_valid, 1);
    chk("t5_pc_en_mis", pc_en, 0);
    step();
    chk("t5_fault", fault, 1);
    chk("t5_cause", fault_cause, 2);
    chk("t5_retired", retired, 2);
    chk("t5_valid_fault", instr_valid, 0);
    step(); step();
    chk("t5_cause_hold", fault_cause, 2);
    chk("t5_no_pc_en", n_pc_en - cnt0, 0);

    // 5b: halt at pc 0x8
    do_reset();
    start = 1'b1; imem_ready = 1'b1;
    exp_instr_q.push_back({32'h0000_0000, 32'hDEAD_0000});
    exp_instr_q.push_back({32'h0000_0004, 32'hDEAD_0004});
    exp_instr_q.push_back({32'h0000_0008, 32'hDEAD_0008});
    exp_next_q.push_back(32'h4);
    exp_next_q.push_back(32'h8);
    step(); start = 1'b0;
    repeat (5) step();
    chk("t5h_instr_pc", instr_pc, 32'h8);
    halt = 1'b1;
    #1;
    chk("t5h_pc_en", pc_en, 0);
    step();
    halt = 1'b0;
    chk("t5h_halted", halted, 1);
    chk("t5h_retired", retired, 3);
    chk("t5h_pc", pc, 32'h8);
    chk("t5h_busy", busy, 0);
    chk("t5h_req", imem_req, 0);
    repeat (3) step();
    chk("t5h_halted_hold", halted, 1);
    chk("t5h_pc_hold", pc, 32'h8);

    // 6: AUTO_START instance, asynchronous reset in WAIT
    ready_a = 1'b1;
    rst_a = 1'b0;
    step();
    chk("t6_req_auto", a_req, 1);
    chk("t6_addr_auto", a_addr, 0);
    step();
    chk("t6_valid", a_valid, 1);
    chk("t6_instr", a_instr, 32'hDEAD_0000);
    step();
    chk("t6_retired1", a_retired, 1);
    chk("t6_addr4", a_addr, 32'h4);
    ready_a = 1'b0;
    step(); step();
    chk("t6_busy_wait", a_busy, 1);
    rst_a = 1'b1;
    #1;
    chk("t6_rst_req", a_req, 0);
    chk("t6_rst_addr", a_addr, 0);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_valid", a_valid, 0);
    chk("t6_rst_pc_en", a_pc_en, 0);
    chk("t6_rst_retired", a_retired, 0);
    chk("t6_rst_instr", a_instr, 0);
    chk("t6_rst_instr_pc", a_instr_pc, 0);
    chk("t6_rst_cause", a_cause, 0);
    chk("t6_rst_flags", {a_fault, a_halted}, 0);
    step();
    rst_a = 1'b0;
    chk("t6_idle_req", a_req, 0);
    step();
    chk("t6_req_again", a_req, 1);
    chk("t6_addr_again", a_addr, 0);
    chk("t6_retired0", a_retired, 0);

    step();
    chk("sb_instr_drained", exp_instr_q.size(), 0);
    chk("sb_next_drained", exp_next_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
